// File: rtl/rst_sequencer.sv
// MCU reset sequencer: power-on hold, debounced reset sources,
// minimum pulse width, staggered release and sticky reset cause.
module rst_sequencer #(
  parameter int NUM_SRC       = 2,
  parameter int NUM_OUT       = 3,
  parameter int POR_CYC       = 1000000,
  parameter int DEBOUNCE_CYC  = 1000000,
  parameter int MIN_PULSE_CYC = 1024,
  parameter int STAGGER_CYC   = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               sw_rst_req,
  input  logic               cause_clr,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic [NUM_SRC+1:0] cause
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PW = $clog2(POR_CYC + 1);
  localparam int MW = $clog2(MIN_PULSE_CYC + 1);
  localparam int SW = $clog2(STAGGER_CYC + 1);
  localparam int CW = (PW > MW) ? ((PW > SW) ? PW : SW)
                                : ((MW > SW) ? MW : SW);

  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] POR_LAST = CW'(POR_CYC - 1);
  localparam logic [CW-1:0] MIN_END  = CW'(MIN_PULSE_CYC);
  localparam logic [CW-1:0] STG_LAST = CW'(STAGGER_CYC - 1);

  localparam logic [NUM_OUT-1:0] OUT_LAST =
    NUM_OUT'(1) << (NUM_OUT - 1);
  localparam logic [NUM_SRC+1:0] CAUSE_POR =
    {{(NUM_SRC + 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_POR,
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t state;

  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;
  logic [NUM_SRC-1:0] deb;
  logic [NUM_SRC-1:0] deb_d;
  logic [DW-1:0]      db_cnt [NUM_SRC];
  logic [CW-1:0]      cnt;

  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC+1:0] cause_set;
  logic               src_lvl;
  logic               req;
  logic               evt;

  assign src_rise  = deb & ~deb_d & src_en;
  assign src_lvl   = |(deb & src_en);
  assign req       = src_lvl | sw_rst_req;
  assign evt       = (|src_rise) | sw_rst_req;
  assign cause_set = {sw_rst_req, src_rise, 1'b0};

  // Synchroniser and debouncer for every source, enabled or not.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= src_in;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cause <= CAUSE_POR;
    end else begin
      cause <= (cause_clr ? '0 : cause) | cause_set;
    end
  end

  // Outputs release lowest index first by shifting zeros in from bit 0.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= ST_POR;
      cnt     <= '0;
      rst_out <= '1;
      busy    <= 1'b1;
    end else begin
      unique case (state)
        ST_POR: begin
          if (req) begin
            state <= ST_ASSERT;
            cnt   <= '0;
          end else if (cnt == POR_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ASSERT: begin
          if (evt) begin
            cnt <= '0;
          end else if (cnt == MIN_END && !src_lvl) begin
            state <= ST_RELEASE;
            cnt   <= '0;
          end else if (cnt != MIN_END) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (req) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            rst_out <= '1;
          end else if (cnt == STG_LAST) begin
            cnt     <= '0;
            rst_out <= rst_out << 1;
            if (rst_out == OUT_LAST) begin
              state <= ST_RUN;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (req) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
          end
        end
        default: begin
          state <= ST_POR;
        end
      endcase
    end
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset controller generating the MCU's active-high peripheral/CPU resets. It provides a counter-timed power-on reset and counter-based debouncing of NUM_SRC asynchronous reset sources plus a synchronous software request. It enforces a minimum reset pulse width, releases NUM_OUT reset domains in a staggered order, and keeps a sticky reset-cause register. It sits between the board pins and the PRESET consumers (CPU, APB master, RAM, peripherals).

## Interface
- NUM_SRC, 2, number of external reset sources (≥1)
- NUM_OUT, 3, number of reset outputs (≥1)
- POR_CYC, 1_000_000, power-on hold cycles after PRESETn release (≥1)
- DEBOUNCE_CYC, 1_000_000, cycles a source must be stable before its debounced value changes (≥1)
- MIN_PULSE_CYC, 1024, minimum cycles all outputs stay asserted per reset event (≥1)
- STAGGER_CYC, 16, cycles between successive output releases (≥1)
- PCLK  in  1  clock
- PRESETn  in  1  reset, asynchronous, active-low
- src_in  in  NUM_SRC  raw reset sources, active-high, asynchronous, bouncing
- src_en  in  NUM_SRC  per-source enable, quasi-static
- sw_rst_req  in  1  synchronous software reset request, single-cycle pulse
- cause_clr  in  1  synchronous clear of cause register
- rst_out  out  NUM_OUT  reset outputs, active-high; index 0 released first
- busy  out  1  high whenever state ≠ RUN
- cause  out  NUM_SRC+2  sticky cause: bit0 POR, bits 1..NUM_SRC = src_in[0..NUM_SRC-1], bit NUM_SRC+1 = software

## Operation
- PRESETn low (async): state=POR, all counters 0, rst_out all 1, busy=1, cause=1 (POR bit only), debounced values 0, sync flops 0.
- Source path per bit: 2-flop synchroniser, then debouncer. The counter increments while the synced value ≠ the debounced value and clears when they are equal. At count DEBOUNCE_CYC the debounced value flips and the counter clears. Pulses shorter than DEBOUNCE_CYC are never seen.
- req = OR(debounced & src_en) | sw_rst_req.
- States: POR, ASSERT, RELEASE, RUN.
- POR: all outputs 1. Count POR_CYC cycles, then go to RELEASE. If req is active, go to ASSERT instead; no cause bit is lost.
- ASSERT: all outputs 1. The counter starts at 0 on entry. Exit to RELEASE when the counter has reached MIN_PULSE_CYC and the debounced enabled sources are all 0.
- RELEASE: an index k starts at 0. Every STAGGER_CYC cycles rst_out[k] goes to 0 and k increments. After rst_out[NUM_OUT-1] deasserts, go to RUN.
- RUN: outputs all 0, busy=0.
- req in RELEASE or RUN: go to ASSERT. All outputs return to 1 on the next edge and the counter restarts. Already-released outputs are re-asserted.
- req in ASSERT (e.g. second source or sw pulse): stay in ASSERT and restart the MIN_PULSE counter.
- cause: on each rising edge of a debounced enabled source, or on sw_rst_req, OR the matching bit in (in any state). cause_clr zeroes all bits. A simultaneous set wins over clear for that bit. The block's own rst_out never clears cause.
- Disabled source: ignored for req and cause; its debouncer still runs.
- Counter widths: $clog2(param+1).

## Timing
- Edges are numbered from 1 = first rising PCLK edge with PRESETn high.
- POR only: rst_out[k] falls at edge POR_CYC + (k+1)·STAGGER_CYC. busy falls on the same edge as rst_out[NUM_OUT-1].
- src_in rising, held stable, sampled at edge e: debounced value high at edge e+2+DEBOUNCE_CYC. rst_out all 1 and cause bit set at edge e+3+DEBOUNCE_CYC.
- sw_rst_req high at edge e: rst_out all 1 and cause bit set at edge e+1. Outputs stay high through at least edge e+MIN_PULSE_CYC.
- ASSERT→RELEASE: rst_out[k] falls STAGGER_CYC·(k+1) edges after leaving ASSERT.
- PRESETn assertion mid-operation: outputs go to 1 immediately (async, no clock needed). The sequence restarts from POR.

## Test plan
Parameters: NUM_SRC=2, NUM_OUT=3, POR_CYC=8, DEBOUNCE_CYC=5, MIN_PULSE_CYC=6, STAGGER_CYC=4.
- Power-on: PRESETn released, no inputs -> rst_out[0..2] fall at edges 12/16/20, busy 0 at edge 20, cause=4'b0001.
- Bounce reject: src_in[0] toggles with 3-cycle pulses for 30 cycles in RUN -> rst_out stays 0, cause unchanged.
- Debounced press: src_in[0] held high from edge 40 for 20 cycles -> rst_out=3'b111 at edge 48, held until source debounced low. Then staggered release 4/8/12 cycles later. cause bit1 set.
- sw pulse during RELEASE: sw_rst_req at the edge after rst_out[0] falls -> all outputs 1 next edge, ≥6 cycles high, then full staggered release. cause bit3 set.
- Masked source and cause clear: src_en=2'b01, src_in[1] held high -> no reset, bit2 clear. Then cause_clr coinciding with sw_rst_req -> cause=4'b1000.
- Async reset mid-RELEASE: PRESETn low between edges -> rst_out=3'b111 before the next edge, cause=4'b0001. POR timing repeats after release.
